// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module  : me_pkg
// Brief   : Shared types and derived search geometry for motion_estimation.
// Revision: 1.0 - initial release
// ============================================================================
package me_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [15:0] sad_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Starting value of the running minimum; any real SAD (max 65280) beats it.
  localparam sad_t SAD_INIT = 16'hFFFF;

  // Candidate offsets per axis.
  function automatic int calc_n(input int macro_dim, input int search_dim);
    return search_dim - macro_dim + 1;
  endfunction

  // Vertical bands: each band covers two candidate rows (A and B).
  function automatic int calc_b(input int macro_dim, input int search_dim);
    return (calc_n(macro_dim, search_dim) + 1) / 2;
  endfunction

  // Data cycles needed for one complete search.
  function automatic int calc_run_len(input int macro_dim, input int search_dim);
    return calc_b(macro_dim, search_dim) * calc_n(macro_dim, search_dim) * macro_dim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motion_estimation_sad_column.sv
`default_nettype none
// ============================================================================
// Module  : sad_column
// Brief   : Combinational SAD of one macroblock column against one window
//           column: per-row absolute differences followed by an adder tree.
// Revision: 1.0 - initial release
// ============================================================================
module sad_column
  import me_pkg::*;
#(
  parameter int MACRO_DIM = 16,
  parameter int SUM_W     = 12
) (
  input  logic [7:0]       cur [0:MACRO_DIM-1],
  input  logic [7:0]       spr [0:MACRO_DIM-1],
  output logic [SUM_W-1:0] col_sad
);

  pixel_t diff [0:MACRO_DIM-1];

  // Per-row absolute difference; always fits in 8 bits.
  for (genvar r = 0; r < MACRO_DIM; r++) begin : g_diff
    assign diff[r] = (cur[r] > spr[r]) ? (cur[r] - spr[r]) : (spr[r] - cur[r]);
  end

  // Sum of all rows; synthesis balances this chain into a tree.
  always_comb begin
    col_sad = '0;
    for (int r = 0; r < MACRO_DIM; r++) begin
      col_sad = col_sad + SUM_W'(diff[r]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/motion_estimation.sv
`default_nettype none
// ============================================================================
// Module  : motion_estimation
// Brief   : Full-search integer-pel block matcher. Streams one macroblock
//           column plus a 17-row window slice per cycle, scores two vertically
//           adjacent candidates at once and reports the minimum SAD.
// Revision: 1.0 - initial release
// ============================================================================
module motion_estimation
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pixel_spr_in [0:MACRO_DIM],
  input  logic [7:0]  pixel_cpr_in [0:MACRO_DIM-1],
  output logic        en_ram,
  output logic        valid,
  output logic        ready,
  output logic [15:0] min_sad
);

  localparam int N      = calc_n(MACRO_DIM, SEARCH_DIM);
  localparam int B      = calc_b(MACRO_DIM, SEARCH_DIM);
  localparam int SUM_W  = $clog2(MACRO_DIM) + 8;
  localparam int COL_W  = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1;
  localparam int DX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int BAND_W = (B > 1) ? $clog2(B) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(MACRO_DIM - 1);
  localparam logic [DX_W-1:0]   DX_LAST   = DX_W'(N - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(B - 1);
  // With an odd offset count the B candidate of the last band lies outside.
  localparam bit                ODD_N     = (N % 2) == 1;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [DX_W-1:0]     dx;
  logic [BAND_W-1:0]   band;
  logic [1:0]          flush_cnt;

  logic [7:0]          spr_a [0:MACRO_DIM-1];
  logic [7:0]          spr_b [0:MACRO_DIM-1];
  logic [SUM_W-1:0]    sad_a;
  logic [SUM_W-1:0]    sad_b;

  sad_t                acc_a;
  sad_t                acc_b;
  sad_t                min_cur;
  sad_t                min_next;
  logic                cmp_pend;
  logic                cmp_b_ok;

  logic                col_last;
  logic                run_last;

  assign col_last = (col == COL_LAST);
  assign run_last = col_last && (dx == DX_LAST) && (band == BAND_LAST);

  // Candidate A sees window rows 0..15 of the slice, candidate B rows 1..16.
  always_comb begin
    for (int r = 0; r < MACRO_DIM; r++) begin
      spr_a[r] = pixel_spr_in[r];
      spr_b[r] = pixel_spr_in[r+1];
    end
  end

  sad_column #(.MACRO_DIM(MACRO_DIM), .SUM_W(SUM_W)) u_sad_a (
    .cur     (pixel_cpr_in),
    .spr     (spr_a),
    .col_sad (sad_a)
  );

  sad_column #(.MACRO_DIM(MACRO_DIM), .SUM_W(SUM_W)) u_sad_b (
    .cur     (pixel_cpr_in),
    .spr     (spr_b),
    .col_sad (sad_b)
  );

  // Update the minimum with A first, then B, so ties keep the earlier one.
  always_comb begin
    min_next = min_cur;
    if (acc_a < min_next) begin
      min_next = acc_a;
    end
    if (cmp_b_ok && (acc_b < min_next)) begin
      min_next = acc_b;
    end
  end

  // Control FSM: stream counters, handshake and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      en_ram    <= 1'b0;
      valid     <= 1'b0;
      min_sad   <= '0;
      col       <= '0;
      dx        <= '0;
      band      <= '0;
      flush_cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            ready  <= 1'b0;
            en_ram <= 1'b1;
            col    <= '0;
            dx     <= '0;
            band   <= '0;
          end
        end
        ST_RUN: begin
          if (col_last) begin
            col <= '0;
            if (dx == DX_LAST) begin
              dx   <= '0;
              band <= band + BAND_W'(1);
            end else begin
              dx <= dx + DX_W'(1);
            end
          end else begin
            col <= col + COL_W'(1);
          end
          if (run_last) begin
            state     <= ST_FLUSH;
            en_ram    <= 1'b0;
            flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          // cnt 0: last compare lands in min_cur; cnt 1: publish; cnt 2: idle.
          flush_cnt <= flush_cnt + 2'd1;
          if (flush_cnt == 2'd1) begin
            valid   <= 1'b1;
            min_sad <= min_cur;
          end
          if (flush_cnt == 2'd2) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: per-candidate accumulation and the minimum compare one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a    <= '0;
      acc_b    <= '0;
      cmp_pend <= 1'b0;
      cmp_b_ok <= 1'b0;
      min_cur  <= SAD_INIT;
    end else begin
      cmp_pend <= en_ram && col_last;
      cmp_b_ok <= !(ODD_N && (band == BAND_LAST));
      if (en_ram) begin
        // Column 0 restarts the sum, which retires the finished candidate.
        acc_a <= (col == '0) ? sad_t'(sad_a) : acc_a + sad_t'(sad_a);
        acc_b <= (col == '0) ? sad_t'(sad_b) : acc_b + sad_t'(sad_b);
      end
      if (state == ST_IDLE) begin
        min_cur <= SAD_INIT;
      end else if (cmp_pend) begin
        min_cur <= min_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motion_estimation.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_motion_estimation
// Brief   : Directed scoreboard bench for motion_estimation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_motion_estimation;

  localparam int MD      = 16;
  localparam int SD      = 48;
  localparam int N       = 33;
  localparam int B       = 17;
  localparam int RUN_LEN = 8976;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  spr [0:MD];
  logic [7:0]  cpr [0:MD-1];
  logic        en_ram;
  logic        valid;
  logic        ready;
  logic [15:0] min_sad;

  motion_estimation #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pixel_spr_in (spr),
    .pixel_cpr_in (cpr),
    .en_ram       (en_ram),
    .valid        (valid),
    .ready        (ready),
    .min_sad      (min_sad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sad;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t       sb[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] win [0:SD-1][0:SD-1];
  logic [7:0] cur [0:MD-1][0:MD-1];

  task automatic check(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic fill(input logic [7:0] wv, input logic [7:0] cv);
    for (int y = 0; y < SD; y++)
      for (int x = 0; x < SD; x++) win[y][x] = wv;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) cur[r][c] = cv;
  endtask

  task automatic patch(input int y, input int x, input logic [7:0] v);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (y + r < SD && x + c < SD) win[y+r][x+c] = v;
  endtask

  task automatic clear_ports();
    for (int k = 0; k <= MD; k++) spr[k] = 8'd0;
    for (int r = 0; r < MD; r++) cpr[r] = 8'd0;
  endtask

  // Issue one search and stream its data; abort_at >= 0 pulls reset mid-run.
  task automatic do_search(input string name, input logic [15:0] exp_sad,
                           input bit hold, input int abort_at);
    int   s_edge;
    int   en_cnt;
    int   it;
    int   guard;
    exp_t e;
    start = 1'b1;
    guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) begin
      check({name, "_ready_timeout"}, 0, 1);
      return;
    end
    @(posedge clk); #1;
    s_edge = cyc;
    if (!hold) start = 1'b0;
    if (abort_at < 0) begin
      e.sad     = exp_sad;
      e.edge_no = s_edge + RUN_LEN + 2;
      e.name    = name;
      sb.push_back(e);
    end
    en_cnt = 0;
    it     = 0;
    for (int b = 0; b < B; b++) begin
      for (int dx = 0; dx < N; dx++) begin
        for (int c = 0; c < MD; c++) begin
          if (it == abort_at) begin
            rst_n = 1'b0;
            #1;
            check({name, "_abort_ready"},   int'(ready),   1);
            check({name, "_abort_en_ram"},  int'(en_ram),  0);
            check({name, "_abort_valid"},   int'(valid),   0);
            check({name, "_abort_min_sad"}, int'(min_sad), 0);
            clear_ports();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            return;
          end
          if (!hold && it == 500) start = 1'b1;
          if (!hold && it == 503) start = 1'b0;
          for (int r = 0; r < MD; r++) cpr[r] = cur[r][c];
          for (int k = 0; k <= MD; k++)
            spr[k] = (2*b + k < SD) ? win[2*b+k][dx+c] : 8'd0;
          if (en_ram) en_cnt++;
          it++;
          @(posedge clk); #1;
        end
      end
    end
    check({name, "_en_ram_cycles"},    en_cnt,        RUN_LEN);
    check({name, "_en_ram_low_after"}, int'(en_ram),  0);
    clear_ports();
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_min_sad"},    int'(min_sad), int'(e.sad));
          check({e.name, "_valid_edge"}, cyc,           e.edge_no);
        end
      end
    end
  end

  initial begin
    int guard;
    clear_ports();
    fill(8'd0, 8'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",   int'(ready),   1);
    check("reset_en_ram",  int'(en_ram),  0);
    check("reset_valid",   int'(valid),   0);
    check("reset_min_sad", int'(min_sad), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All zero pixels: perfect match everywhere.
    fill(8'd0, 8'd0);
    do_search("zero", 16'd0, 1'b0, -1);

    // Only the excluded B candidate at dy=33 matches rows 33..47; best valid
    // candidate (32,0) misses on row 32 only: 150 x 16 columns.
    fill(8'd200, 8'd50);
    patch(33, 0, 8'd50);
    do_search("excl_b", 16'd2400, 1'b0, -1);

    // Reset pulled mid-run: no valid may follow.
    fill(8'd13, 8'd10);
    do_search("abort", 16'd0, 1'b0, 1000);

    // start held high: three back-to-back searches.
    fill(8'd13, 8'd10);
    do_search("flat_768", 16'd768, 1'b1, -1);
    fill(8'd0, 8'd255);
    do_search("max_65280", 16'd65280, 1'b1, -1);
    fill(8'd200, 8'd50);
    patch(5, 7, 8'd50);
    do_search("patch_5_7", 16'd0, 1'b0, -1);

    // Match at the far corner, a candidate A of the last band.
    fill(8'd200, 8'd50);
    patch(32, 32, 8'd50);
    do_search("patch_32_32", 16'd0, 1'b0, -1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
